// File: rtl/video_timing_pkg.sv
// Shared timing constants, state type and sync-position helpers for the
// 720x480p59.94 video timing controller.
package video_timing_pkg;

    localparam int H_ACT_DEF  = 720;
    localparam int H_FP_DEF   = 16;
    localparam int H_SYNC_DEF = 62;
    localparam int H_BP_DEF   = 60;
    localparam int H_TOT_DEF  = H_ACT_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;

    localparam int V_ACT_DEF  = 480;
    localparam int V_FP_DEF   = 9;
    localparam int V_SYNC_DEF = 6;
    localparam int V_BP_DEF   = 30;
    localparam int V_TOT_DEF  = V_ACT_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    // Sync pulses start right after the front porch and last 'width' positions.
    function automatic int syncFirst(input int act, input int fp);
        return act + fp;
    endfunction

    function automatic int syncLast(input int act, input int fp, input int width);
        return act + fp + width - 1;
    endfunction

    localparam int HS_FIRST_DEF = syncFirst(H_ACT_DEF, H_FP_DEF);
    localparam int HS_LAST_DEF  = syncLast(H_ACT_DEF, H_FP_DEF, H_SYNC_DEF);
    localparam int VS_FIRST_DEF = syncFirst(V_ACT_DEF, V_FP_DEF);
    localparam int VS_LAST_DEF  = syncLast(V_ACT_DEF, V_FP_DEF, V_SYNC_DEF);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } VtState;

endpackage

// File: rtl/video_sync_dly.sv
// Tick-enabled shift pipe that delays {DE, HSYNC, VSYNC} by DEPTH ticks so
// they line up with pixel data returned by the upstream source.
module video_sync_dly
    import video_timing_pkg::*;
#(
    parameter int DEPTH  = 2,
    parameter bit HS_POL = 1'b0,
    parameter bit VS_POL = 1'b0
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       tick_i,
    input  logic [2:0] sync_i,
    output logic [2:0] sync_o
);

    localparam logic [2:0] IDLE_LEVELS = {1'b0, ~HS_POL, ~VS_POL};

    if (DEPTH == 0) begin : gBypass
        assign sync_o = sync_i;
    end else begin : gPipe
        logic [2:0] pipe_q [DEPTH];

        // Shift one stage per pixel tick; reset loads the inactive levels.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                for (int i = 0; i < DEPTH; i++) pipe_q[i] <= IDLE_LEVELS;
            end else if (tick_i) begin
                pipe_q[0] <= sync_i;
                for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
            end
        end

        assign sync_o = pipe_q[DEPTH-1];
    end

endmodule

// File: rtl/video_timing_ctl.sv
// Video timing controller: pixel-tick divider, raster counters, run/drain
// state machine, pixel request stage and latency-matched DE/HSYNC/VSYNC.
module video_timing_ctl
    import video_timing_pkg::*;
#(
    parameter int H_ACT   = H_ACT_DEF,
    parameter int H_FP    = H_FP_DEF,
    parameter int H_SYNC  = H_SYNC_DEF,
    parameter int H_BP    = H_BP_DEF,
    parameter int V_ACT   = V_ACT_DEF,
    parameter int V_FP    = V_FP_DEF,
    parameter int V_SYNC  = V_SYNC_DEF,
    parameter int V_BP    = V_BP_DEF,
    parameter bit HS_POL  = 1'b0,
    parameter bit VS_POL  = 1'b0,
    parameter int CKE_DIV = 1,
    parameter int REQ_LAT = 2
) (
    input  logic       CK,
    input  logic       XAR,
    input  logic       EN_i,
    output logic       CKE_o,
    output logic       DE_o,
    output logic       HD_o,
    output logic       VD_o,
    output logic       REQ_o,
    output logic [9:0] X_o,
    output logic [9:0] Y_o,
    output logic       FRM_o,
    output logic       BUSY_o
);

    localparam int H_TOT = H_ACT + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACT + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_ACT_W  = 10'(H_ACT);
    localparam logic [9:0] V_ACT_W  = 10'(V_ACT);
    localparam logic [9:0] H_LAST   = 10'(H_TOT - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOT - 1);
    localparam logic [9:0] HS_FIRST = 10'(syncFirst(H_ACT, H_FP));
    localparam logic [9:0] HS_LAST  = 10'(syncLast(H_ACT, H_FP, H_SYNC));
    localparam logic [9:0] VS_FIRST = 10'(syncFirst(V_ACT, V_FP));
    localparam logic [9:0] VS_LAST  = 10'(syncLast(V_ACT, V_FP, V_SYNC));
    localparam logic [3:0] CKE_LAST = 4'(CKE_DIV - 1);
    localparam logic [2:0] IDLE_LEVELS = {1'b0, ~HS_POL, ~VS_POL};

    if (H_TOT > 1023 || V_TOT > 1023 || CKE_DIV < 1 || CKE_DIV > 16 ||
        REQ_LAT < 0 || REQ_LAT > 7) begin : gBadConfig
        $error("video_timing_ctl: unsupported timing configuration");
    end

    logic [3:0] ckeCnt_q, ckeCnt_d;
    logic       cke_q;
    VtState     state_q, state_d;
    logic [9:0] hCnt_q, hCnt_d, vCnt_q, vCnt_d;
    logic [9:0] x_q, x_d, y_q, y_d;
    logic       req_q, req_d, frm_q, frm_d;
    logic [2:0] stage_q, stage_d;
    logic [2:0] syncOut;
    logic       running, active, hsAct, vsAct;

    assign ckeCnt_d = (ckeCnt_q == CKE_LAST) ? 4'd0 : ckeCnt_q + 4'd1;

    // Free-running pixel-tick divider; the strobe is registered so it is low in reset.
    always_ff @(posedge CK or negedge XAR) begin
        if (!XAR) begin
            ckeCnt_q <= 4'd0;
            cke_q    <= 1'b0;
        end else begin
            ckeCnt_q <= ckeCnt_d;
            cke_q    <= (ckeCnt_q == CKE_LAST);
        end
    end

    // Next state, raster position and request-stage values for the coming tick.
    always_comb begin
        state_d = state_q;
        hCnt_d  = hCnt_q;
        vCnt_d  = vCnt_q;
        running = (state_q != IDLE) || EN_i;
        active  = (hCnt_q < H_ACT_W) && (vCnt_q < V_ACT_W);
        hsAct   = (hCnt_q >= HS_FIRST) && (hCnt_q <= HS_LAST);
        vsAct   = (vCnt_q >= VS_FIRST) && (vCnt_q <= VS_LAST);

        unique case (state_q)
            IDLE:    if (EN_i) state_d = RUN;
            RUN:     if (!EN_i) state_d = DRAIN;
            DRAIN: begin
                if (EN_i) state_d = RUN;
                else if (hCnt_q == H_LAST && vCnt_q == V_LAST) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (running) begin
            if (hCnt_q == H_LAST) begin
                hCnt_d = 10'd0;
                vCnt_d = (vCnt_q == V_LAST) ? 10'd0 : vCnt_q + 10'd1;
            end else begin
                hCnt_d = hCnt_q + 10'd1;
            end
        end
        if (state_d == IDLE) begin
            hCnt_d = 10'd0;
            vCnt_d = 10'd0;
        end

        req_d   = running && active;
        frm_d   = (state_q == RUN || (state_q == IDLE && EN_i)) &&
                  hCnt_q == 10'd0 && vCnt_q == 10'd0;
        x_d     = req_d ? hCnt_q : x_q;
        y_d     = req_d ? vCnt_q : y_q;
        stage_d = running ? {active, hsAct ? HS_POL : ~HS_POL, vsAct ? VS_POL : ~VS_POL}
                          : IDLE_LEVELS;
    end

    // State register, advanced only on pixel ticks.
    always_ff @(posedge CK or negedge XAR) begin
        if (!XAR) state_q <= IDLE;
        else if (cke_q) state_q <= state_d;
    end

    // Raster counters and request-stage outputs, advanced only on pixel ticks.
    always_ff @(posedge CK or negedge XAR) begin
        if (!XAR) begin
            hCnt_q  <= 10'd0;
            vCnt_q  <= 10'd0;
            req_q   <= 1'b0;
            frm_q   <= 1'b0;
            x_q     <= 10'd0;
            y_q     <= 10'd0;
            stage_q <= IDLE_LEVELS;
        end else if (cke_q) begin
            hCnt_q  <= hCnt_d;
            vCnt_q  <= vCnt_d;
            req_q   <= req_d;
            frm_q   <= frm_d;
            x_q     <= x_d;
            y_q     <= y_d;
            stage_q <= stage_d;
        end
    end

    video_sync_dly #(
        .DEPTH  (REQ_LAT),
        .HS_POL (HS_POL),
        .VS_POL (VS_POL)
    ) uSyncDly (
        .clk_i  (CK),
        .rst_ni (XAR),
        .tick_i (cke_q),
        .sync_i (stage_q),
        .sync_o (syncOut)
    );

    assign CKE_o  = cke_q;
    assign DE_o   = syncOut[2];
    assign HD_o   = syncOut[1];
    assign VD_o   = syncOut[0];
    assign REQ_o  = req_q;
    assign FRM_o  = frm_q;
    assign X_o    = x_q;
    assign Y_o    = y_q;
    assign BUSY_o = (state_q != IDLE);

endmodule

// File: tb/tb_video_timing_ctl.sv
// Directed bench for video_timing_ctl. Horizontal timing is the real 858-tick
// line; vertical timing is shortened to 8 lines (4 active, FP 1, sync 2, BP 1)
// so several whole frames fit in a short run. A second instance checks the
// divide-by-4 pixel tick.
module tb_video_timing_ctl;
    import video_timing_pkg::*;

    logic CK = 1'b0;
    logic XAR = 1'b0;
    logic EN = 1'b0;
    logic EN4 = 1'b0;

    logic cke, de, hd, vd, req, frm, busy;
    logic [9:0] x, y;
    logic cke4, de4, hd4, vd4, req4, frm4, busy4;
    logic [9:0] x4, y4;

    int nAsserts = 0;
    int nFails = 0;

    int s = 0;
    int reqCnt = 0, deCnt = 0, hdLow = 0, vdLow = 0, frmCnt = 0;
    int k = 0;
    int req4Samples = 0, cke4Samples = 0, badChange = 0;
    logic prevCke4;
    logic [25:0] prevOut4;
    int f0, f1;

    video_timing_ctl #(
        .H_ACT(720), .H_FP(16), .H_SYNC(62), .H_BP(60),
        .V_ACT(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0), .CKE_DIV(1), .REQ_LAT(2)
    ) dut (
        .CK(CK), .XAR(XAR), .EN_i(EN), .CKE_o(cke), .DE_o(de), .HD_o(hd),
        .VD_o(vd), .REQ_o(req), .X_o(x), .Y_o(y), .FRM_o(frm), .BUSY_o(busy)
    );

    video_timing_ctl #(
        .H_ACT(720), .H_FP(16), .H_SYNC(62), .H_BP(60),
        .V_ACT(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0), .CKE_DIV(4), .REQ_LAT(2)
    ) dut4 (
        .CK(CK), .XAR(XAR), .EN_i(EN4), .CKE_o(cke4), .DE_o(de4), .HD_o(hd4),
        .VD_o(vd4), .REQ_o(req4), .X_o(x4), .Y_o(y4), .FRM_o(frm4), .BUSY_o(busy4)
    );

    // Free-running CK, period 10.
    always #5 CK = ~CK;

    // Safety net so the run can never hang.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus(input logic en, input logic xar);
        EN  = en;
        XAR = xar;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        nAsserts++;
        assert (observed === expected) else begin
            nFails++;
            $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic clearStats();
        reqCnt = 0; deCnt = 0; hdLow = 0; vdLow = 0; frmCnt = 0;
    endtask

    // Step the main instance to sample index 'target', accumulating statistics.
    task automatic advanceTo(input int target);
        while (s < target) begin
            @(negedge CK);
            s++;
            reqCnt += int'(req);
            deCnt  += int'(de);
            hdLow  += int'(!hd);
            vdLow  += int'(!vd);
            frmCnt += int'(frm);
        end
    endtask

    function automatic logic [25:0] out4();
        return {de4, hd4, vd4, req4, frm4, busy4, x4, y4};
    endfunction

    // Step the divide-by-4 instance, flagging output changes outside tick cycles.
    task automatic advance4To(input int target);
        while (k < target) begin
            @(negedge CK);
            k++;
            if (out4() !== prevOut4 && prevCke4 !== 1'b1) badChange++;
            prevOut4 = out4();
            prevCke4 = cke4;
            req4Samples += int'(req4);
            cke4Samples += int'(cke4);
        end
    endtask

    initial begin
        // Reset values
        repeat (3) @(negedge CK);
        checkOutput("rst_cke", cke, 1'b0);
        checkOutput("rst_de", de, 1'b0);
        checkOutput("rst_hd", hd, 1'b1);
        checkOutput("rst_vd", vd, 1'b1);
        checkOutput("rst_req", req, 1'b0);
        checkOutput("rst_frm", frm, 1'b0);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_x", x, 10'd0);
        checkOutput("rst_y", y, 10'd0);
        checkOutput("rst_cke4", cke4, 1'b0);

        // Divide-by-4 tick pattern, then a first line on the slow instance
        applyStimulus(1'b0, 1'b1);
        k = 0;
        prevOut4 = out4();
        prevCke4 = cke4;
        for (int i = 1; i <= 8; i++) begin
            advance4To(i);
            checkOutput("cke4_phase", cke4, (i % 4 == 0) ? 1'b1 : 1'b0);
        end
        checkOutput("cke_div1_const", cke, 1'b1);
        EN4 = 1'b1;
        req4Samples = 0;
        cke4Samples = 0;
        badChange = 0;
        advance4To(9);
        checkOutput("div4_req_first", req4, 1'b1);
        checkOutput("div4_frm_first", frm4, 1'b1);
        checkOutput("div4_cke_low", cke4, 1'b0);
        advance4To(12);
        checkOutput("div4_frm_held", frm4, 1'b1);
        advance4To(13);
        checkOutput("div4_frm_drop", frm4, 1'b0);
        checkOutput("div4_x1", x4, 10'd1);
        advance4To(16);
        checkOutput("div4_de_before", de4, 1'b0);
        advance4To(17);
        checkOutput("div4_de_rise", de4, 1'b1);
        advance4To(2885);
        checkOutput("div4_x719", x4, 10'd719);
        advance4To(2889);
        checkOutput("div4_req_end", req4, 1'b0);
        checkOutput("div4_x_hold", x4, 10'd719);
        advance4To(3440);
        checkOutput("div4_req_samples", req4Samples, 2880);
        checkOutput("div4_cke_count", cke4Samples, 858);
        checkOutput("div4_offtick_change", badChange, 0);
        checkOutput("div4_req_gap", req4, 1'b0);
        advance4To(3441);
        checkOutput("div4_line1_req", req4, 1'b1);
        checkOutput("div4_line1_y", y4, 10'd1);
        checkOutput("div4_line1_x", x4, 10'd0);
        EN4 = 1'b0;

        // Main instance still idle
        checkOutput("idle_busy", busy, 1'b0);
        checkOutput("idle_req", req, 1'b0);

        // Frame 0 from EN rise
        applyStimulus(1'b1, 1'b1);
        s = -1;
        clearStats();
        advanceTo(0);
        checkOutput("f0_frm", frm, 1'b1);
        checkOutput("f0_req", req, 1'b1);
        checkOutput("f0_busy", busy, 1'b1);
        checkOutput("f0_x", x, 10'd0);
        checkOutput("f0_de_lat", de, 1'b0);
        advanceTo(1);
        checkOutput("f0_frm_drop", frm, 1'b0);
        checkOutput("f0_de_lat1", de, 1'b0);
        checkOutput("f0_x1", x, 10'd1);
        advanceTo(2);
        checkOutput("f0_de_rise", de, 1'b1);
        advanceTo(719);
        checkOutput("f0_x719", x, 10'd719);
        advanceTo(720);
        checkOutput("f0_req_end", req, 1'b0);
        checkOutput("f0_x_hold", x, 10'd719);
        advanceTo(721);
        checkOutput("f0_de_tail", de, 1'b1);
        advanceTo(722);
        checkOutput("f0_de_fall", de, 1'b0);
        advanceTo(737);
        checkOutput("f0_hd_before", hd, 1'b1);
        advanceTo(738);
        checkOutput("f0_hd_start", hd, 1'b0);
        advanceTo(799);
        checkOutput("f0_hd_last", hd, 1'b0);
        advanceTo(800);
        checkOutput("f0_hd_end", hd, 1'b1);
        advanceTo(858);
        checkOutput("f0_line1_req", req, 1'b1);
        checkOutput("f0_line1_x", x, 10'd0);
        checkOutput("f0_line1_y", y, 10'd1);
        advanceTo(3293);
        checkOutput("f0_last_x", x, 10'd719);
        checkOutput("f0_last_y", y, 10'd3);
        advanceTo(3432);
        checkOutput("f0_vblank_req", req, 1'b0);
        checkOutput("f0_y_hold", y, 10'd3);
        advanceTo(4291);
        checkOutput("f0_vd_before", vd, 1'b1);
        advanceTo(4292);
        checkOutput("f0_vd_start", vd, 1'b0);
        advanceTo(6007);
        checkOutput("f0_vd_last", vd, 1'b0);
        advanceTo(6008);
        checkOutput("f0_vd_end", vd, 1'b1);
        advanceTo(6863);
        checkOutput("f0_req_count", reqCnt, 2880);
        checkOutput("f0_de_count", deCnt, 2880);
        checkOutput("f0_hd_low", hdLow, 496);
        checkOutput("f0_vd_low", vdLow, 1716);
        checkOutput("f0_frm_count", frmCnt, 1);
        clearStats();
        advanceTo(6864);
        checkOutput("f1_frm", frm, 1'b1);
        checkOutput("f1_y", y, 10'd0);

        // Drop EN on line 2 of frame 1: the frame completes, then IDLE
        advanceTo(8590);
        applyStimulus(1'b0, 1'b1);
        advanceTo(13726);
        checkOutput("drain_busy", busy, 1'b1);
        advanceTo(13727);
        checkOutput("drain_idle_busy", busy, 1'b0);
        checkOutput("drain_req_count", reqCnt, 2880);
        checkOutput("drain_frm_count", frmCnt, 1);
        checkOutput("drain_x_hold", x, 10'd719);
        checkOutput("drain_y_hold", y, 10'd3);
        clearStats();
        advanceTo(13827);
        checkOutput("idle_no_req", reqCnt, 0);
        checkOutput("idle_no_de", deCnt, 0);
        checkOutput("idle_no_frm", frmCnt, 0);
        checkOutput("idle_hd_low", hdLow, 0);
        checkOutput("idle_vd_low", vdLow, 0);
        checkOutput("idle_busy_low", busy, 1'b0);

        // Re-raise EN: the next tick starts a frame
        applyStimulus(1'b1, 1'b1);
        clearStats();
        f0 = 13828;
        advanceTo(f0);
        checkOutput("restart_frm", frm, 1'b1);
        checkOutput("restart_req", req, 1'b1);
        checkOutput("restart_x", x, 10'd0);
        checkOutput("restart_y", y, 10'd0);
        checkOutput("restart_busy", busy, 1'b1);

        // Five-tick EN glitch mid-frame: DRAIN then back to RUN, no disturbance
        advanceTo(f0 + 1000);
        applyStimulus(1'b0, 1'b1);
        advanceTo(f0 + 1005);
        checkOutput("glitch_busy", busy, 1'b1);
        applyStimulus(1'b1, 1'b1);
        advanceTo(f0 + 1006);
        checkOutput("glitch_x", x, 10'd148);
        checkOutput("glitch_y", y, 10'd1);
        checkOutput("glitch_req", req, 1'b1);
        advanceTo(f0 + 6863);
        checkOutput("glitch_req_count", reqCnt, 2880);
        checkOutput("glitch_frm_count", frmCnt, 1);
        f1 = f0 + 6864;
        advanceTo(f1);
        checkOutput("glitch_next_frm", frm, 1'b1);

        // Asynchronous reset mid-frame at (300, 2)
        advanceTo(f1 + 2016);
        checkOutput("pre_rst_x", x, 10'd300);
        checkOutput("pre_rst_y", y, 10'd2);
        checkOutput("pre_rst_de", de, 1'b1);
        #2;
        applyStimulus(1'b1, 1'b0);
        #1;
        checkOutput("arst_de", de, 1'b0);
        checkOutput("arst_hd", hd, 1'b1);
        checkOutput("arst_vd", vd, 1'b1);
        checkOutput("arst_req", req, 1'b0);
        checkOutput("arst_busy", busy, 1'b0);
        checkOutput("arst_x", x, 10'd0);
        checkOutput("arst_cke", cke, 1'b0);
        @(negedge CK);
        checkOutput("arst_held_req", req, 1'b0);
        applyStimulus(1'b1, 1'b1);
        @(negedge CK);
        checkOutput("post_rst_cke", cke, 1'b1);
        checkOutput("post_rst_frm_wait", frm, 1'b0);
        @(negedge CK);
        checkOutput("post_rst_frm", frm, 1'b1);
        checkOutput("post_rst_req", req, 1'b1);
        checkOutput("post_rst_x", x, 10'd0);
        checkOutput("post_rst_busy", busy, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule

// File: doc/video_timing_ctl.md
Name: video_timing_ctl

Overview:
Timing controller that sequences the TMDS/DVI encoder path for 720x480p59.94. It generates the clock-enable strobe, DE/HSYNC/VSYNC, and a pixel request with X/Y coordinates for the upstream pixel source. Sync and DE are delayed to match the source's fixed latency, so DE_o aligns with returned pixel data at the encoder input. A run/drain state machine starts and stops video only on frame boundaries.

Parameters:
H_ACT, 720, active pixels per line
H_FP, 16, horizontal front porch (ticks)
H_SYNC, 62, HSYNC width (ticks)
H_BP, 60, horizontal back porch (ticks)
V_ACT, 480, active lines
V_FP, 9, vertical front porch (lines)
V_SYNC, 6, VSYNC width (lines)
V_BP, 30, vertical back porch (lines)
HS_POL, 0, HSYNC active level
VS_POL, 0, VSYNC active level
CKE_DIV, 1, CK cycles per pixel tick (1..16)
REQ_LAT, 2, pixel source latency in ticks (0..7)

Ports:
CK  in  1  clock
XAR  in  1  asynchronous active-low reset
EN_i  in  1  run request, level
CKE_o  out  1  pixel tick strobe to encoder CKE_i
DE_o  out  1  data enable, latency-aligned
HD_o  out  1  HSYNC, latency-aligned, polarity HS_POL
VD_o  out  1  VSYNC, latency-aligned, polarity VS_POL
REQ_o  out  1  pixel request, one per active pixel
X_o  out  10  column of current request
Y_o  out  10  row of current request
FRM_o  out  1  one-tick frame-start pulse (0,0 request tick)
BUSY_o  out  1  state != IDLE

Behaviour:
- Clock and reset: one clock, CK. Reset is asynchronous and active-low, XAR.
- Reset values: CKE_o=0, DE_o=0, REQ_o=0, FRM_o=0, BUSY_o=0, X_o=0, Y_o=0, HD_o=~HS_POL, VD_o=~VS_POL. The state machine resets to IDLE. The delay pipe resets to the inactive levels.
- CKE divider: a mod-CKE_DIV counter runs continuously after reset. CKE_o=1 for one CK cycle when the count is 0. With CKE_DIV=1, CKE_o is constantly 1 from the first cycle after reset. All registers below update only on CK cycles where CKE_o=1 (a "tick").
- Counters: H_TOT = H_ACT+H_FP+H_SYNC+H_BP = 858. V_TOT = 525.
  - hcnt runs 0..857 and wraps to 0. vcnt increments when hcnt wraps, and vcnt wraps from 524 to 0.
  - Active region: hcnt<720 && vcnt<480.
  - HSYNC active for hcnt in 736..797. VSYNC active for vcnt in 489..494, level-based per line, with no half-line offset.
- Request stage (undelayed):
  - REQ_o=1 on ticks where the state is RUN or DRAIN and the position is active.
  - X_o=hcnt and Y_o=vcnt on request ticks. X_o and Y_o hold their last value otherwise.
  - FRM_o=1 on the tick with hcnt=0, vcnt=0 in RUN.
- Output stage: DE, HS and VS are each delayed REQ_LAT ticks through the pipe. The pipe shifts only on ticks. With REQ_LAT=0 they are registered in the same stage as REQ_o.
- State machine:
  - IDLE: counters held at 0. Pipe input is the inactive levels. Leave to RUN on a tick with EN_i=1; that tick is counter position (0,0) and FRM_o=1.
  - RUN: counters free-run. EN_i=0 on a tick moves to DRAIN.
  - DRAIN: counters continue. EN_i=1 returns to RUN with no counter disturbance. The tick at (857,524) with EN_i=0 moves to IDLE and counters reset to 0. The frame always completes.
  - IDLE to RUN never produces a partial frame.
- Drain tail: after entering IDLE, the pipe still flushes REQ_LAT ticks of valid blanking, then holds the inactive levels. BUSY_o drops on the IDLE transition.
- EN_i changes between ticks are sampled only on ticks.
- XAR asserted mid-frame: all outputs take their reset values immediately. There is no recovery frame; a restart requires EN_i.
- Widths: hcnt and vcnt are 10 bits. The totals are checked by an elaboration-time assertion (≤1023).

Decomposition:
- Shared package `video_timing_pkg` holds:
  - the 720x480p59.94 default constants (H/V active, porches, sync, totals);
  - the state enum IDLE/RUN/DRAIN;
  - localparams for the sync start/end positions.
- One sub-module, `video_sync_dly`: a parameterised REQ_LAT-deep, tick-enabled 3-bit shift pipe with reset value {0, ~HS_POL, ~VS_POL}.

Test Plan:
- Reset, then EN_i=1 with CKE_DIV=1, REQ_LAT=2: FRM_o pulses at the first tick. REQ_o is high for 720 ticks per line and 480 lines. DE_o rises exactly 2 ticks after REQ_o. X_o goes 0..719 and Y_o goes 0..479.
- Frame measurement: HD_o low for 62 ticks starting 738 ticks after the line-start REQ (with delay). Line period 858 ticks. VD_o low for 6 lines. Frame period 858×525=450450 ticks.
- CKE_DIV=4: CKE_o pulses every 4th CK. All outputs change only on those cycles. Line period 3432 CK.
- EN_i dropped at line 100: remaining lines complete. Transition to IDLE after tick (857,524). BUSY_o=0. No REQ after. Re-raise EN_i: FRM_o at the next tick.
- EN_i pulsed low for 5 ticks mid-frame (DRAIN then RUN): no counter discontinuity, and the REQ count per frame stays 345600.
- XAR low at hcnt=300, vcnt=200: DE_o=0, HD_o=VD_o=1, REQ_o=0 asynchronously. After release with EN_i=1, the first FRM_o occurs on the first tick.
